alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares a single `Alu_16bit` instance among `NREQ` requesters. Each requester issues an operand pair and a 3-bit opcode over a valid/ready handshake. The arbiter grants one request at a time, captures its operands, drives the shared ALU and returns a registered result tagged with the requester ID. It sits between the client blocks and the one physical ALU, so no client ever drives the ALU directly.

## Interface
- `NREQ`, default 4: number of requesters, 2..8; `ID_W = $clog2(NREQ)` is derived, not overridable.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `req_valid` input NREQ: bit i asserts that requester i has a pending operation.
- `req_a` input NREQ*16: operand A; requester i occupies bits [16i+15:16i].
- `req_b` input NREQ*16: operand B, same packing as `req_a`.
- `req_op` input NREQ*3: opcode; requester i occupies bits [3i+2:3i].
- `req_ready` output NREQ: one-hot grant; request i is accepted on a cycle where `req_valid[i] && req_ready[i]`.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: consumer accepts the result.
- `rsp_id` output ID_W: index of the requester that owns the result.
- `rsp_data` output 16: ALU result.
- `rsp_err` output 1: illegal-opcode flag (see Configuration).
- `ops_done` output 16: count of completed responses, wraps modulo 2^16.

## Operation
- Opcodes:
  - 001 add a+b.
  - 010 sub a−b.
  - 011 and.
  - 100 or.
  - 101 xor.
  - 000, 110, 111 give result 0.
- Arithmetic is 16-bit modulo 2^16. Carry and borrow are discarded, e.g. 0x0000−0x0001 = 0xFFFF.
- FSM states:
  - IDLE
    - `req_ready` is combinational: a one-hot bit for the winner, or all zero if no `req_valid` is set.
    - Winner is the first set `req_valid` bit searched from `ptr` upward, wrapping at NREQ−1 → 0.
    - On a grant, register a/b/op/id and go to EXEC. Otherwise stay in IDLE.
  - EXEC
    - The registered a/b/op drive the ALU.
    - Register the ALU output into `rsp_data`, with `rsp_id` and `rsp_err`.
    - Set `rsp_valid` to 1 and go to RESP.
  - RESP
    - Hold `rsp_valid`, `rsp_data`, `rsp_id` and `rsp_err` stable until `rsp_ready`.
    - On `rsp_valid && rsp_ready`: set `rsp_valid` to 0, increment `ops_done` and go to IDLE.
- Round-robin pointer `ptr`:
  - Reset value is 0.
  - On a grant to requester i, `ptr` becomes (i+1) mod NREQ.
  - `ptr` is unchanged on idle cycles.
- `req_ready` is 0 in EXEC and RESP. Requests arriving then wait.
- A requester keeps `req_valid` and its operands stable until granted. The arbiter samples the operands only on the grant cycle.
- Simultaneous requests from all requesters are granted in strict rotation, so no requester waits more than NREQ−1 grants.
- `rsp_ready` held high in IDLE or EXEC has no effect.
- Reset mid-operation (EXEC or RESP) discards the in-flight operation. No response is produced and `ops_done` is not incremented.

## Timing
- Reset values:
  - state IDLE.
  - `ptr` 0.
  - `rsp_valid` 0, `rsp_data` 0x0000, `rsp_id` 0, `rsp_err` 0.
  - `ops_done` 0.
  - `req_ready` 0 for every cycle where `rst_n` is 0.
- Latency: grant at edge N (IDLE), result registered at edge N+1 (EXEC), so `rsp_valid` is high from cycle N+2.
- With `rsp_ready` held high, peak throughput is one operation per 3 cycles.
- Back-pressure: a low `rsp_ready` stalls in RESP indefinitely with outputs frozen.
- The ALU path is combinational between the operand registers and `rsp_data`, a single cycle.

## Configuration
- `ALU_ARB_ERR_EN` defined:
  - `rsp_err` is 1 in the same response as opcodes 000, 110 or 111, and `rsp_data` is 0x0000.
  - Legal opcodes give `rsp_err` 0.
- `ALU_ARB_ERR_EN` undefined:
  - `rsp_err` is tied to 0.
  - Illegal opcodes still return 0x0000 silently.
- All other behaviour is identical in both builds.

## Test plan
- Reset then idle: `rst_n` low for 2 cycles, no requests. All outputs hold their reset values and `req_ready` is 0.
- Single add: req0 a=0x0001, b=0x0001, op=001, `rsp_ready`=1.
  - Grant at cycle N.
  - `rsp_valid` at N+2 with `rsp_data`=0x0002, `rsp_id`=0.
  - `ops_done`=1 after the response handshake.
- Wrap arithmetic:
  - req1 a=0x0000, b=0x0001, op=010 gives 0xFFFF.
  - a=0xFFFF, b=0x0001, op=001 gives 0x0000.
- Fairness: NREQ=4, all valid continuously, ops 001/011/100/101 with a=1, b=1.
  - Grant order is 0,1,2,3,0.
  - Results are 0x0002, 0x0001, 0x0001, 0x0000.
- Back-pressure and reset: hold `rsp_ready`=0 for 5 cycles in RESP.
  - Outputs stay frozen and `req_ready` stays 0.
  - Then assert `rst_n`=0 for 1 cycle: `rsp_valid` is 0 and `ops_done` is unchanged at 0.
- Illegal opcode: op=111 with a=5, b=3.
  - `rsp_data`=0x0000.
  - `rsp_err`=1 with `ALU_ARB_ERR_EN` defined, and 0 without it.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 16-bit ALU among NREQ requesters
// Optional illegal-opcode flag on rsp_err when ALU_ARB_ERR_EN is defined.

module alu_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [2:0]  i_op,
    output logic [15:0] o_y
);
    always_comb begin
        o_y = 16'h0000;
        case (i_op)
            3'b001:  o_y = i_a + i_b;
            3'b010:  o_y = i_a - i_b;
            3'b011:  o_y = i_a & i_b;
            3'b100:  o_y = i_a | i_b;
            3'b101:  o_y = i_a ^ i_b;
            default: o_y = 16'h0000;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    input  logic [NREQ*3-1:0]    req_op,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_data,
    output logic                 rsp_err,
    output logic [15:0]          ops_done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [ID_W-1:0] r_ptr;
    logic [15:0]     r_a;
    logic [15:0]     r_b;
    logic [2:0]      r_op;
    logic [ID_W-1:0] r_id;
    logic            r_rsp_valid;
    logic [15:0]     r_rsp_data;
    logic [ID_W-1:0] r_rsp_id;
    logic [15:0]     r_ops_done;
    logic [NREQ-1:0] w_grant;
    logic [ID_W-1:0] w_grant_idx;
    logic            w_any;
    logic [15:0]     w_alu_y;

    // First valid requester at or after r_ptr, wrapping past NREQ-1.
    always_comb begin : p_arb
        int j;
        w_grant     = '0;
        w_grant_idx = '0;
        w_any       = 1'b0;
        j           = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_any && req_valid[j[ID_W-1:0]]) begin
                w_any                    = 1'b1;
                w_grant_idx              = j[ID_W-1:0];
                w_grant[j[ID_W-1:0]]     = 1'b1;
            end
        end
    end

    assign req_ready = (rst_n && r_state == IDLE) ? w_grant : '0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    alu_16bit u_alu (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_y  (w_alu_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_a         <= 16'h0000;
            r_b         <= 16'h0000;
            r_op        <= 3'b000;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 16'h0000;
            r_rsp_id    <= '0;
            r_ops_done  <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a   <= req_a[16*w_grant_idx +: 16];
                        r_b   <= req_b[16*w_grant_idx +: 16];
                        r_op  <= req_op[3*w_grant_idx +: 3];
                        r_id  <= w_grant_idx;
                        r_ptr <= (int'(w_grant_idx) == NREQ - 1) ? '0 : w_grant_idx + 1'b1;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_alu_y;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_done  <= r_ops_done + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_ERR_EN
    logic r_rsp_err;
    logic w_illegal;

    assign w_illegal = (r_op == 3'b000) || (r_op == 3'b110) || (r_op == 3'b111);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_err <= w_illegal;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with directed vectors

module tb_alu_arbiter;
    localparam int NREQ = 4;
`ifdef ALU_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [63:0]     req_a;
    logic [63:0]     req_b;
    logic [11:0]     req_op;
    logic [NREQ-1:0] req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_data;
    logic            rsp_err;
    logic [15:0]     ops_done;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ops_done  (ops_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d data=0x%0h expected none", rsp_id, rsp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        req_op[3*id +: 3]  = op;
        req_valid[id]      = 1'b1;
    endtask

    // Called #1 after a posedge; returns #1 after the grant edge.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         input logic [15:0] exp_data, input logic exp_err, input bit push);
        bit got;
        got = 1'b0;
        set_req(id, a, b, op);
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: requester %0d got no grant, expected one", id);
        end else begin
            check("grant_onehot", 32'(req_ready), 32'(1 << id));
            if (push) sb.push_back('{id: 2'(id), data: exp_data, err: exp_err});
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 0);
        check({tag, "_ops_done"}, 32'(ops_done), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
    endtask

    initial begin
        logic [1:0]  exp_order [5];
        logic [15:0] fair_data [4];
        int          n_grant;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;

        // Reset: two cycles, the second with every request raised.
        @(negedge clk);
        check_reset_outputs("rst1");
        req_valid = 4'hF;
        @(negedge clk);
        check_reset_outputs("rst2");
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle");

        // Single add with latency check.
        @(posedge clk);
        #1;
        issue(0, 16'h0001, 16'h0001, 3'b001, 16'h0002, 1'b0, 1'b1);
        @(negedge clk);
        check("lat_exec_valid", 32'(rsp_valid), 0);
        check("lat_exec_ready", 32'(req_ready), 0);
        @(negedge clk);
        check("lat_resp_valid", 32'(rsp_valid), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ops_done_1", 32'(ops_done), 1);

        // Wrap arithmetic.
        @(posedge clk);
        #1;
        issue(1, 16'h0000, 16'h0001, 3'b010, 16'hFFFF, 1'b0, 1'b1);
        issue(3, 16'hFFFF, 16'h0001, 3'b001, 16'h0000, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("ops_done_3", 32'(ops_done), 3);

        // Fairness: all four held valid, pointer is back at 0.
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        fair_data = '{16'h0002, 16'h0001, 16'h0001, 16'h0000};
        set_req(0, 16'h0001, 16'h0001, 3'b001);
        set_req(1, 16'h0001, 16'h0001, 3'b011);
        set_req(2, 16'h0001, 16'h0001, 3'b100);
        set_req(3, 16'h0001, 16'h0001, 3'b101);
        n_grant = 0;
        for (int t = 0; t < 100 && n_grant < 5; t++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check("fair_grant", 32'(req_ready), 32'(1 << exp_order[n_grant]));
                sb.push_back('{id: exp_order[n_grant], data: fair_data[exp_order[n_grant]], err: 1'b0});
                n_grant++;
            end
        end
        check("fair_grant_count", 32'(n_grant), 5);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        check("ops_done_8", 32'(ops_done), 8);

        // Back-pressure then reset while in RESP.
        rsp_ready = 1'b0;
        issue(2, 16'h00F0, 16'h0F0F, 3'b101, 16'h0FFF, 1'b0, 1'b0);
        set_req(1, 16'h1234, 16'h0001, 3'b001);
        @(negedge clk);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_data", 32'(rsp_data), 32'h0FFF);
            check("bp_id", 32'(rsp_id), 2);
            check("bp_ready", 32'(req_ready), 0);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("rst_mid_req_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 32'(rsp_valid), 0);
        check("rst_mid_ops_done", 32'(ops_done), 0);
        repeat (3) @(negedge clk);
        check("rst_mid_no_rsp", 32'(rsp_valid), 0);

        // Illegal opcodes.
        @(posedge clk);
        #1;
        issue(0, 16'h0005, 16'h0003, 3'b111, 16'h0000, ERR_EN, 1'b1);
        issue(1, 16'h0005, 16'h0003, 3'b000, 16'h0000, ERR_EN, 1'b1);
        issue(2, 16'h0005, 16'h0003, 3'b110, 16'h0000, ERR_EN, 1'b1);
        issue(3, 16'h0005, 16'h0003, 3'b101, 16'h0006, 1'b0, 1'b1);

        for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);
        check("ops_done_final", 32'(ops_done), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
